// File: rtl/dispatcher_pkg.sv
// Shared constants and types for the dispatcher issue stage.
package dispatcher_pkg;

    localparam int unsigned TAG_W_DEF = 5;
    localparam int unsigned OP_W_DEF  = 6;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NUM_REGS  = 32;

    localparam logic                 TRUE         = 1'b1;
    localparam logic                 FALSE        = 1'b0;
    localparam logic [DATA_W-1:0]    ZERO         = '0;
    localparam logic [TAG_W_DEF-1:0] RENAMED_ZERO = '0;
    localparam logic [OP_W_DEF-1:0]  NOP          = '0;

    // Decoded instruction held in the issue slot (opcode kept separately, its width is a parameter)
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic              is_ls;
        logic              has_rd;
    } slot_fields_t;

    // An instruction renames rd only if it writes a register other than x0
    function automatic logic writes_reg(input logic has_rd, input logic [REG_W-1:0] rd);
        return has_rd && (rd != REG_W'(0));
    endfunction

endpackage

// File: rtl/dispatcher_operand_resolve.sv
// Per-source operand resolution: register file, ROB, then CDB (ALU before LSB).
// DISPATCH_CDB_BYPASS_EN: fold same-cycle CDB results into the operand; otherwise
// flag a collision so the caller holds issue for one cycle.
module dispatcher_operand_resolve
    import dispatcher_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic              busy,
    input  logic [TAG_W-1:0]  tag,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              rob_rdy,
    input  logic [DATA_W-1:0] rob_val,
    input  logic              alu_has_result,
    input  logic [TAG_W-1:0]  alias_from_alu,
    input  logic [DATA_W-1:0] result_from_alu,
    input  logic              lsb_has_result,
    input  logic [TAG_W-1:0]  alias_from_lsb,
    input  logic [DATA_W-1:0] result_from_lsb,
    output logic [TAG_W-1:0]  q_c,
    output logic [DATA_W-1:0] v_c,
    output logic              stall_c
);

    logic alu_hit;
    logic lsb_hit;

    assign alu_hit = alu_has_result && (alias_from_alu == tag);
    assign lsb_hit = lsb_has_result && (alias_from_lsb == tag);

`ifndef DISPATCH_CDB_BYPASS_EN
    // CDB data is only needed when bypassing
    logic unused_cdb_data;
    assign unused_cdb_data = ^{result_from_alu, result_from_lsb};
`endif

    // Priority mux: not busy -> RF, ROB ready -> ROB, CDB hit -> CDB, else wait on tag
    always_comb begin
        q_c     = TAG_W'(RENAMED_ZERO);
        v_c     = rf_data;
        stall_c = FALSE;
        if (busy) begin
            if (rob_rdy) begin
                v_c = rob_val;
`ifdef DISPATCH_CDB_BYPASS_EN
            end else if (alu_hit) begin
                v_c = result_from_alu;
            end else if (lsb_hit) begin
                v_c = result_from_lsb;
`endif
            end else begin
                q_c = tag;
                v_c = ZERO;
`ifndef DISPATCH_CDB_BYPASS_EN
                stall_c = alu_hit || lsb_hit;
`endif
            end
        end
    end

endmodule

// File: rtl/dispatcher.sv
// Single-slot issue stage: allocates a ROB tag, renames sources through the
// register-status table and issues to the RS (ALU ops) or the LSB.
// Optional build macro: DISPATCH_CDB_BYPASS_EN (same-cycle CDB operand bypass).
module dispatcher
    import dispatcher_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned OP_W  = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [OP_W-1:0]   dec_optype,
    input  logic [DATA_W-1:0] dec_pc,
    input  logic [DATA_W-1:0] dec_imm,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic [REG_W-1:0]  dec_rs2,
    input  logic [REG_W-1:0]  dec_rd,
    input  logic              dec_is_ls,
    input  logic              dec_has_rd,
    input  logic              rob_full,
    input  logic [TAG_W-1:0]  rob_free_tag,
    output logic              rob_alloc,
    output logic [REG_W-1:0]  rf_addr1,
    output logic [REG_W-1:0]  rf_addr2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    output logic [TAG_W-1:0]  rob_q1,
    output logic [TAG_W-1:0]  rob_q2,
    input  logic              rob_rdy1,
    input  logic              rob_rdy2,
    input  logic [DATA_W-1:0] rob_val1,
    input  logic [DATA_W-1:0] rob_val2,
    input  logic              commit_valid,
    input  logic [REG_W-1:0]  commit_rd,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              alu_has_result,
    input  logic [TAG_W-1:0]  alias_from_alu,
    input  logic [DATA_W-1:0] result_from_alu,
    input  logic              lsb_has_result,
    input  logic [TAG_W-1:0]  alias_from_lsb,
    input  logic [DATA_W-1:0] result_from_lsb,
    input  logic              rs_full,
    input  logic              lsb_full,
    output logic              rdy_to_rs,
    output logic              rdy_to_lsb,
    output logic [OP_W-1:0]   optype_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [TAG_W-1:0]  rd_alias,
    output logic [TAG_W-1:0]  Qi_o,
    output logic [TAG_W-1:0]  Qj_o,
    output logic [DATA_W-1:0] Vi_o,
    output logic [DATA_W-1:0] Vj_o,
    output logic [DATA_W-1:0] imm_o
);

    logic              slot_valid;
    slot_fields_t      slot;
    logic [OP_W-1:0]   slot_optype;
    logic [NUM_REGS-1:0] busy_tbl;
    logic [TAG_W-1:0]  tag_tbl [NUM_REGS];

    logic              busy1, busy2;
    logic [TAG_W-1:0]  tag1, tag2;
    logic [TAG_W-1:0]  q1, q2;
    logic [DATA_W-1:0] v1, v2;
    logic              stall1, stall2;
    logic              target_full;
    logic              issue;
    logic              accept;

    assign busy1 = busy_tbl[slot.rs1];
    assign busy2 = busy_tbl[slot.rs2];
    assign tag1  = tag_tbl[slot.rs1];
    assign tag2  = tag_tbl[slot.rs2];

    assign rf_addr1 = slot.rs1;
    assign rf_addr2 = slot.rs2;
    assign rob_q1   = busy1 ? tag1 : TAG_W'(RENAMED_ZERO);
    assign rob_q2   = busy2 ? tag2 : TAG_W'(RENAMED_ZERO);

    dispatcher_operand_resolve #(.TAG_W(TAG_W)) u_resolve_1 (
        .busy            (busy1),
        .tag             (tag1),
        .rf_data         (rf_data1),
        .rob_rdy         (rob_rdy1),
        .rob_val         (rob_val1),
        .alu_has_result  (alu_has_result),
        .alias_from_alu  (alias_from_alu),
        .result_from_alu (result_from_alu),
        .lsb_has_result  (lsb_has_result),
        .alias_from_lsb  (alias_from_lsb),
        .result_from_lsb (result_from_lsb),
        .q_c             (q1),
        .v_c             (v1),
        .stall_c         (stall1)
    );

    dispatcher_operand_resolve #(.TAG_W(TAG_W)) u_resolve_2 (
        .busy            (busy2),
        .tag             (tag2),
        .rf_data         (rf_data2),
        .rob_rdy         (rob_rdy2),
        .rob_val         (rob_val2),
        .alu_has_result  (alu_has_result),
        .alias_from_alu  (alias_from_alu),
        .result_from_alu (result_from_alu),
        .lsb_has_result  (lsb_has_result),
        .alias_from_lsb  (alias_from_lsb),
        .result_from_lsb (result_from_lsb),
        .q_c             (q2),
        .v_c             (v2),
        .stall_c         (stall2)
    );

    // Issue and handshake decisions
    assign target_full = slot.is_ls ? lsb_full : rs_full;
    assign issue       = slot_valid && rdy && !rollback && !rob_full && !target_full
                         && !stall1 && !stall2;
    assign dec_ready   = rdy && !rollback && (!slot_valid || issue);
    assign accept      = dec_valid && dec_ready;

    assign rdy_to_rs  = issue && !slot.is_ls;
    assign rdy_to_lsb = issue && slot.is_ls;
    assign rob_alloc  = issue;

    // Payload is zero while the slot is empty
    assign optype_o = slot_valid ? slot_optype  : OP_W'(NOP);
    assign pc_o     = slot_valid ? slot.pc      : ZERO;
    assign imm_o    = slot_valid ? slot.imm     : ZERO;
    assign rd_alias = slot_valid ? rob_free_tag : TAG_W'(RENAMED_ZERO);
    assign Qi_o     = slot_valid ? q1           : TAG_W'(RENAMED_ZERO);
    assign Qj_o     = slot_valid ? q2           : TAG_W'(RENAMED_ZERO);
    assign Vi_o     = slot_valid ? v1           : ZERO;
    assign Vj_o     = slot_valid ? v2           : ZERO;

    // Instruction slot: capture on accept, empty on issue or rollback
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid  <= FALSE;
            slot        <= '0;
            slot_optype <= OP_W'(NOP);
        end else if (rdy) begin
            if (rollback) begin
                slot_valid <= FALSE;
            end else if (accept) begin
                slot_valid  <= TRUE;
                slot_optype <= dec_optype;
                slot        <= '{pc: dec_pc, imm: dec_imm, rs1: dec_rs1, rs2: dec_rs2,
                                 rd: dec_rd, is_ls: dec_is_ls, has_rd: dec_has_rd};
            end else if (issue) begin
                slot_valid <= FALSE;
            end
        end
    end

    // Register-status table: commit clears a matching tag, a same-cycle rename overrides it
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_tbl <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                tag_tbl[i] <= TAG_W'(RENAMED_ZERO);
            end
        end else if (rdy) begin
            if (rollback) begin
                busy_tbl <= '0;
            end else begin
                if (commit_valid && (tag_tbl[commit_rd] == commit_tag)) begin
                    busy_tbl[commit_rd] <= FALSE;
                end
                if (issue && writes_reg(slot.has_rd, slot.rd)) begin
                    busy_tbl[slot.rd] <= TRUE;
                    tag_tbl[slot.rd]  <= rob_free_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatcher.sv
// Self-checking bench for dispatcher: directed scenarios followed by random
// traffic, all compared against a behavioural model of the issue stage.
module tb_dispatcher;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        dec_valid, dec_ready;
    logic [5:0]  dec_optype;
    logic [31:0] dec_pc, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_is_ls, dec_has_rd;
    logic        rob_full, rob_alloc;
    logic [4:0]  rob_free_tag;
    logic [4:0]  rf_addr1, rf_addr2;
    logic [31:0] rf_data1, rf_data2;
    logic [4:0]  rob_q1, rob_q2;
    logic        rob_rdy1, rob_rdy2;
    logic [31:0] rob_val1, rob_val2;
    logic        commit_valid;
    logic [4:0]  commit_rd, commit_tag;
    logic        alu_has_result, lsb_has_result;
    logic [4:0]  alias_from_alu, alias_from_lsb;
    logic [31:0] result_from_alu, result_from_lsb;
    logic        rs_full, lsb_full;
    logic        rdy_to_rs, rdy_to_lsb;
    logic [5:0]  optype_o;
    logic [31:0] pc_o, Vi_o, Vj_o, imm_o;
    logic [4:0]  rd_alias, Qi_o, Qj_o;

    // Environment: register file and ROB value store
    logic [31:0] rf_mem      [32];
    logic        rob_rdy_tbl [32];
    logic [31:0] rob_val_tbl [32];

    assign rf_data1 = rf_mem[rf_addr1];
    assign rf_data2 = rf_mem[rf_addr2];
    assign rob_rdy1 = rob_rdy_tbl[rob_q1];
    assign rob_rdy2 = rob_rdy_tbl[rob_q2];
    assign rob_val1 = rob_val_tbl[rob_q1];
    assign rob_val2 = rob_val_tbl[rob_q2];

    always #5 clk = ~clk;

    dispatcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_optype(dec_optype),
        .dec_pc(dec_pc), .dec_imm(dec_imm), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_is_ls(dec_is_ls), .dec_has_rd(dec_has_rd),
        .rob_full(rob_full), .rob_free_tag(rob_free_tag), .rob_alloc(rob_alloc),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .rob_q1(rob_q1), .rob_q2(rob_q2), .rob_rdy1(rob_rdy1), .rob_rdy2(rob_rdy2),
        .rob_val1(rob_val1), .rob_val2(rob_val2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .alu_has_result(alu_has_result), .alias_from_alu(alias_from_alu),
        .result_from_alu(result_from_alu),
        .lsb_has_result(lsb_has_result), .alias_from_lsb(alias_from_lsb),
        .result_from_lsb(result_from_lsb),
        .rs_full(rs_full), .lsb_full(lsb_full),
        .rdy_to_rs(rdy_to_rs), .rdy_to_lsb(rdy_to_lsb),
        .optype_o(optype_o), .pc_o(pc_o), .rd_alias(rd_alias),
        .Qi_o(Qi_o), .Qj_o(Qj_o), .Vi_o(Vi_o), .Vj_o(Vj_o), .imm_o(imm_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the pending instruction and the rename map
    bit          m_valid;
    logic [5:0]  m_optype;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    bit          m_is_ls, m_has_rd;
    bit          m_busy [32];
    logic [4:0]  m_tag  [32];

    // Expected values for the current cycle
    bit          e_issue;
    logic [4:0]  e_q1, e_q2;
    logic [31:0] e_v1, e_v2;
    bit          e_col1, e_col2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Where does the operand of architectural register rs come from this cycle?
    task automatic resolve(input logic [4:0] rs, output logic [4:0] q, output logic [31:0] v,
                           output bit col);
        logic [4:0] t;
        q   = 5'd0;
        v   = rf_mem[rs];
        col = 1'b0;
        if (m_busy[rs]) begin
            t = m_tag[rs];
            if (rob_rdy_tbl[t]) begin
                v = rob_val_tbl[t];
            end else begin
`ifdef DISPATCH_CDB_BYPASS_EN
                if (alu_has_result && alias_from_alu == t) v = result_from_alu;
                else if (lsb_has_result && alias_from_lsb == t) v = result_from_lsb;
                else begin q = t; v = 32'd0; end
`else
                q   = t;
                v   = 32'd0;
                col = (alu_has_result && alias_from_alu == t) ||
                      (lsb_has_result && alias_from_lsb == t);
`endif
            end
        end
    endtask

    task automatic exp_cycle();
        bit full;
        resolve(m_rs1, e_q1, e_v1, e_col1);
        resolve(m_rs2, e_q2, e_v2, e_col2);
        full    = m_is_ls ? lsb_full : rs_full;
        e_issue = m_valid && rdy && !rollback && !rob_full && !full && !e_col1 && !e_col2;
    endtask

    // Compare all outputs mid-cycle against the model
    task automatic check_cycle();
        @(negedge clk);
        exp_cycle();
        chk("rdy_to_rs",  32'(rdy_to_rs),  32'(e_issue && !m_is_ls));
        chk("rdy_to_lsb", 32'(rdy_to_lsb), 32'(e_issue && m_is_ls));
        chk("rob_alloc",  32'(rob_alloc),  32'(e_issue));
        if (rdy && !rollback) chk("dec_ready", 32'(dec_ready), 32'(!m_valid || e_issue));
        if (m_valid) begin
            chk("Qi", 32'(Qi_o), 32'(e_q1));
            chk("Qj", 32'(Qj_o), 32'(e_q2));
            chk("Vi", Vi_o, e_v1);
            chk("Vj", Vj_o, e_v2);
            chk("optype", 32'(optype_o), 32'(m_optype));
            chk("pc", pc_o, m_pc);
            chk("imm", imm_o, m_imm);
            chk("rd_alias", 32'(rd_alias), 32'(rob_free_tag));
            chk("rf_addr1", 32'(rf_addr1), 32'(m_rs1));
            chk("rob_q2", 32'(rob_q2), m_busy[m_rs2] ? 32'(m_tag[m_rs2]) : 32'd0);
        end else begin
            chk("Qi_idle", 32'(Qi_o), 32'd0);
            chk("Vi_idle", Vi_o, 32'd0);
            chk("pc_idle", pc_o, 32'd0);
            chk("rd_alias_idle", 32'(rd_alias), 32'd0);
        end
    endtask

    // Apply this cycle's effect to the model, then cross the clock edge
    task automatic advance();
        bit acc;
        exp_cycle();
        if (rdy) begin
            if (rollback) begin
                m_valid = 1'b0;
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                acc = dec_valid && (!m_valid || e_issue);
                if (commit_valid && m_tag[commit_rd] == commit_tag) m_busy[commit_rd] = 1'b0;
                if (e_issue && m_has_rd && m_rd != 5'd0) begin
                    m_busy[m_rd] = 1'b1;
                    m_tag[m_rd]  = rob_free_tag;
                end
                if (acc) begin
                    m_valid = 1'b1; m_optype = dec_optype; m_pc = dec_pc; m_imm = dec_imm;
                    m_rs1 = dec_rs1; m_rs2 = dec_rs2; m_rd = dec_rd;
                    m_is_ls = dec_is_ls; m_has_rd = dec_has_rd;
                end else if (e_issue) begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        check_cycle();
        advance();
    endtask

    task automatic set_idle();
        rdy = 1'b1; rollback = 1'b0; dec_valid = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        commit_valid = 1'b0; commit_rd = 5'd0; commit_tag = 5'd0;
        alu_has_result = 1'b0; alias_from_alu = 5'd0; result_from_alu = 32'd0;
        lsb_has_result = 1'b0; alias_from_lsb = 5'd0; result_from_lsb = 32'd0;
        rob_free_tag = 5'd1;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input bit ls);
        dec_valid = 1'b1; dec_optype = 6'($urandom); dec_pc = $urandom; dec_imm = $urandom;
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_is_ls = ls; dec_has_rd = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = $urandom; rob_rdy_tbl[i] = 1'b0; rob_val_tbl[i] = $urandom;
            m_busy[i] = 1'b0; m_tag[i] = 5'd0;
        end
        rf_mem[0] = 32'd0; rf_mem[1] = 32'd5; rf_mem[2] = 32'd7;
        m_valid = 1'b0; m_optype = '0; m_pc = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_is_ls = 1'b0; m_has_rd = 1'b0;
        set_idle();
        offer(5'd0, 5'd0, 5'd0, 1'b0);
        dec_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_cycle();
        chk("rst_dec_ready", 32'(dec_ready), 32'd1);
        chk("rst_rdy_to_rs", 32'(rdy_to_rs), 32'd0);
        chk("rst_rob_alloc", 32'(rob_alloc), 32'd0);
        chk("rst_Vi", Vi_o, 32'd0);
        advance();

        // First issue: ADD x3 = x1, x2
        offer(5'd1, 5'd2, 5'd3, 1'b0);
        cyc();
        offer(5'd3, 5'd0, 5'd5, 1'b0); rob_free_tag = 5'd4;
        check_cycle();
        chk("first_strobe", 32'(rdy_to_rs), 32'd1);
        chk("first_Vi", Vi_o, 32'd5);
        chk("first_Vj", Vj_o, 32'd7);
        chk("first_alias", 32'(rd_alias), 32'd4);
        advance();

        // RAW on x3: pending, then ROB-ready
        offer(5'd3, 5'd0, 5'd0, 1'b0); rob_free_tag = 5'd5;
        check_cycle();
        chk("raw_Qi", 32'(Qi_o), 32'd4);
        chk("raw_Vi", Vi_o, 32'd0);
        advance();
        rob_rdy_tbl[4] = 1'b1; rob_val_tbl[4] = 32'd9;
        check_cycle();
        chk("rob_Qi", 32'(Qi_o), 32'd0);
        chk("rob_Vi", Vi_o, 32'd9);
        advance();

        // CDB broadcast of tag 4 while the reader sits in the slot
        dec_valid = 1'b0; rob_rdy_tbl[4] = 1'b0;
        alu_has_result = 1'b1; alias_from_alu = 5'd4; result_from_alu = 32'h11;
        check_cycle();
`ifdef DISPATCH_CDB_BYPASS_EN
        chk("cdb_Vi", Vi_o, 32'h11);
        chk("cdb_issue", 32'(rdy_to_rs), 32'd1);
`else
        chk("cdb_Qi", 32'(Qi_o), 32'd4);
        chk("cdb_stall", 32'(rdy_to_rs), 32'd0);
`endif
        advance();
        alu_has_result = 1'b0; rob_rdy_tbl[4] = 1'b1; rob_val_tbl[4] = 32'h11;
        offer(5'd1, 5'd2, 5'd7, 1'b0);
        check_cycle();
`ifndef DISPATCH_CDB_BYPASS_EN
        chk("cdb_late_Vi", Vi_o, 32'h11);
        chk("cdb_late_issue", 32'(rdy_to_rs), 32'd1);
`endif
        advance();

        // Back-pressure from the RS, store offered meanwhile
        offer(5'd2, 5'd1, 5'd0, 1'b1); rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_cycle();
            chk("bp_strobe", 32'(rdy_to_rs), 32'd0);
            chk("bp_dec_ready", 32'(dec_ready), 32'd0);
            advance();
        end
        rs_full = 1'b0;
        check_cycle();
        chk("bp_release", 32'(rdy_to_rs), 32'd1);
        advance();
        offer(5'd4, 5'd4, 5'd3, 1'b0);
        check_cycle();
        chk("store_lsb", 32'(rdy_to_lsb), 32'd1);
        advance();

        // Commit of x3/tag 4 in the same cycle as renaming x3 to tag 6
        rob_free_tag = 5'd6; commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 5'd4;
        rob_rdy_tbl[6] = 1'b0;
        offer(5'd3, 5'd0, 5'd0, 1'b0);
        check_cycle();
        chk("rename_alias", 32'(rd_alias), 32'd6);
        advance();
        dec_valid = 1'b0; rs_full = 1'b1;
        check_cycle();
        chk("rename_Qi", 32'(Qi_o), 32'd6);
        advance();
        commit_valid = 1'b0;
        check_cycle();
        chk("stale_commit_Qi", 32'(Qi_o), 32'd6);
        advance();

        // Rollback while stalled
        rs_full = 1'b0; rollback = 1'b1; offer(5'd3, 5'd0, 5'd0, 1'b0);
        check_cycle();
        chk("rb_strobe", 32'(rdy_to_rs), 32'd0);
        chk("rb_alloc", 32'(rob_alloc), 32'd0);
        advance();
        rollback = 1'b0;
        check_cycle();
        chk("rb_dec_ready", 32'(dec_ready), 32'd1);
        advance();
        dec_valid = 1'b0;
        check_cycle();
        chk("rb_Qi", 32'(Qi_o), 32'd0);
        chk("rb_Vi", Vi_o, rf_mem[3]);
        advance();

        // Random traffic over a small register/tag range to force dependencies
        for (int c = 0; c < 3000; c++) begin
            rdy      = ($urandom % 10) != 0;
            rollback = ($urandom % 40) == 0;
            rob_full = ($urandom % 10) == 0;
            rs_full  = ($urandom % 5) == 0;
            lsb_full = ($urandom % 5) == 0;
            rob_free_tag = 5'(1 + $urandom % 7);
            if (($urandom % 10) < 7) begin
                offer(5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
                      ($urandom % 10) < 3);
                dec_has_rd = ($urandom % 5) != 0;
            end else begin
                dec_valid = 1'b0;
            end
            commit_valid = ($urandom % 10) < 3;
            commit_rd    = 5'($urandom % 8);
            commit_tag   = ($urandom % 2) ? m_tag[commit_rd] : 5'(1 + $urandom % 7);
            alu_has_result = ($urandom % 10) < 3;
            alias_from_alu = 5'(1 + $urandom % 7);
            result_from_alu = $urandom;
            lsb_has_result = ($urandom % 10) < 3;
            alias_from_lsb = 5'(1 + $urandom % 7);
            result_from_lsb = $urandom;
            for (int i = 0; i < 32; i++) begin
                rob_rdy_tbl[i] = ($urandom % 3) == 0;
                rob_val_tbl[i] = $urandom;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
